// File: rtl/gmii_rx_frame_parser_if.sv
// GMII receive byte stream in, stripped frame bytes plus end-of-frame status out.
// Ports: i_speed1000, i_gmii_data/valid/err (PHY side); o_rec_data/valid/end, o_rec_len, o_crc_err/o_len_err/o_phy_err (buffer side).
// slave = the parser; master = the upstream PHY / frame-buffer environment.
interface gmii_rx_frame_parser_if;
    logic        i_speed1000;
    logic [7:0]  i_gmii_data;
    logic        i_gmii_valid;
    logic        i_gmii_err;
    logic [7:0]  o_rec_data;
    logic        o_rec_valid;
    logic        o_rec_end;
    logic [11:0] o_rec_len;
    logic        o_crc_err;
    logic        o_len_err;
    logic        o_phy_err;

    modport slave (
        input  i_speed1000, i_gmii_data, i_gmii_valid, i_gmii_err,
        output o_rec_data, o_rec_valid, o_rec_end, o_rec_len, o_crc_err, o_len_err, o_phy_err
    );

    modport master (
        output i_speed1000, i_gmii_data, i_gmii_valid, i_gmii_err,
        input  o_rec_data, o_rec_valid, o_rec_end, o_rec_len, o_crc_err, o_len_err, o_phy_err
    );
endinterface

// File: rtl/gmii_rx_frame_parser.sv
// GMII RX front end: strips preamble/SFD (and optionally FCS), checks CRC-32 and length, pulses end with status.
// Latency: o_rec_valid one cycle after the byte that shifts it out; o_rec_end at T+2 (1000) / T+3 (10/100) after the last byte.
// Backpressure: none; the PHY stream cannot be stalled. Ports: i_rxc, i_rst (async, active high), bus (slave modport).
module gmii_rx_frame_parser #(
    parameter bit P_STRIP_FCS = 1'b1,
    parameter int P_MIN_PRE   = 1,
    parameter int P_MAX_PRE   = 15,
    parameter int P_MIN_LEN   = 64,
    parameter int P_MAX_LEN   = 1518
) (
    input  logic                   i_rxc,
    input  logic                   i_rst,
    gmii_rx_frame_parser_if.slave  bus
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_FIN  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            valid_d;
    logic [7:0]      pre_cnt;
    logic [31:0]     crc;
    logic [11:0]     frame_cnt;
    logic [2:0]      dly_cnt;
    logic [3:0][7:0] dly;
    logic            phy_err;
    logic [7:0]      rec_data_q;
    logic            rec_valid_q;

    logic vld;
    logic end_det;
    logic start_det;
    logic runt;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign vld       = bus.i_gmii_valid;
    // At 10/100 the byte strobe may drop for one cycle between bytes, so only
    // two consecutive low cycles mark the end of the frame.
    assign end_det   = bus.i_speed1000 ? !vld : (!vld && !valid_d);
    // valid_d resets to 1 so a frame already in flight at reset release never
    // looks like a fresh rising edge of RX_DV.
    assign start_det = vld && !valid_d && (bus.i_gmii_data == 8'h55);
    assign runt      = (frame_cnt < 12'd4);

    // State register
    always_ff @(posedge i_rxc or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (vld) next_state = start_det ? S_PRE : S_DROP;
            end
            S_PRE: begin
                if (vld) begin
                    if (bus.i_gmii_data == 8'h55)
                        next_state = (32'(pre_cnt) >= P_MAX_PRE) ? S_DROP : S_PRE;
                    else if (bus.i_gmii_data == 8'hD5 && 32'(pre_cnt) >= P_MIN_PRE)
                        next_state = S_DATA;
                    else
                        next_state = S_DROP;
                end else if (end_det) begin
                    next_state = S_IDLE;
                end
            end
            S_DATA: begin
                if (end_det) next_state = S_FIN;
            end
            // FIN also accepts a new preamble so a 1-cycle inter-frame gap works.
            S_FIN: begin
                if (vld) next_state = start_det ? S_PRE : S_DROP;
                else     next_state = S_IDLE;
            end
            S_DROP: begin
                if (end_det) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: preamble counter, CRC, byte counter, FCS delay line, output register
    always_ff @(posedge i_rxc or posedge i_rst) begin
        if (i_rst) begin
            valid_d     <= 1'b1;
            pre_cnt     <= '0;
            crc         <= CRC_INIT;
            frame_cnt   <= '0;
            dly_cnt     <= '0;
            dly         <= '0;
            phy_err     <= 1'b0;
            rec_data_q  <= '0;
            rec_valid_q <= 1'b0;
        end else begin
            valid_d     <= vld;
            rec_valid_q <= 1'b0;

            if (next_state == S_PRE && state != S_PRE)
                pre_cnt <= 8'd1;
            else if (state == S_PRE && vld && bus.i_gmii_data == 8'h55)
                pre_cnt <= pre_cnt + 8'd1;

            if (next_state == S_DATA && state != S_DATA) begin
                crc       <= CRC_INIT;
                frame_cnt <= '0;
                dly_cnt   <= '0;
                phy_err   <= 1'b0;
            end else if (state == S_DATA && vld) begin
                crc     <= crc32_byte(crc, bus.i_gmii_data);
                phy_err <= phy_err | bus.i_gmii_err;
                if (frame_cnt != 12'hFFF) frame_cnt <= frame_cnt + 12'd1;
                if (P_STRIP_FCS) begin
                    // A byte leaves only once four newer bytes sit behind it,
                    // so the trailing FCS stays trapped and is discarded.
                    dly <= {dly[2:0], bus.i_gmii_data};
                    if (dly_cnt == 3'd4) begin
                        rec_data_q  <= dly[3];
                        rec_valid_q <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 3'd1;
                    end
                end else begin
                    rec_data_q  <= bus.i_gmii_data;
                    rec_valid_q <= 1'b1;
                end
            end
        end
    end

    // Output logic: status is only presented during the FIN pulse
    always_comb begin
        bus.o_rec_data  = rec_data_q;
        bus.o_rec_valid = rec_valid_q;
        bus.o_rec_end   = 1'b0;
        bus.o_rec_len   = '0;
        bus.o_crc_err   = 1'b0;
        bus.o_len_err   = 1'b0;
        bus.o_phy_err   = 1'b0;
        if (state == S_FIN) begin
            bus.o_rec_end = 1'b1;
            if (P_STRIP_FCS) bus.o_rec_len = runt ? 12'd0 : (frame_cnt - 12'd4);
            else             bus.o_rec_len = frame_cnt;
            bus.o_crc_err = (crc != CRC_RESIDUE) || runt;
            bus.o_len_err = (32'(frame_cnt) < P_MIN_LEN) || (32'(frame_cnt) > P_MAX_LEN);
            bus.o_phy_err = phy_err;
        end
    end

endmodule

// File: doc/gmii_rx_frame_parser.md
Name: gmii_rx_frame_parser

Overview:
- RX-side front end that feeds the RGMII frame buffer's i_rec_data/i_rec_valid/i_rec_end interface.
- Takes byte-wide GMII receive data already de-DDR'd from the RGMII PHY, locates preamble and SFD, and strips them.
- Optionally strips the 4-byte FCS, checks CRC-32 and frame length, and emits a one-cycle end pulse with status.
- Single clock domain (PHY receive clock).

Parameters:
- P_STRIP_FCS, 1, 1 = FCS bytes not forwarded on o_rec_data; 0 = forwarded.
- P_MIN_PRE, 1, minimum count of 0x55 bytes before 0xD5 for the SFD to be accepted.
- P_MAX_PRE, 15, preamble longer than this aborts the frame.
- P_MIN_LEN, 64, minimum frame bytes after SFD, FCS included.
- P_MAX_LEN, 1518, maximum frame bytes after SFD, FCS included.

Ports:
- i_rxc  in  1  receive clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_speed1000  in  1  1 = gigabit (contiguous bytes); 0 = 10/100 (byte strobes may have 1-cycle gaps).
- i_gmii_data  in  8  received byte.
- i_gmii_valid  in  1  byte strobe / RX_DV.
- i_gmii_err  in  1  RX_ER, sampled with valid.
- o_rec_data  out  8  frame byte, no preamble/SFD.
- o_rec_valid  out  1  o_rec_data qualifier.
- o_rec_end  out  1  one-cycle pulse after the last o_rec_valid of a frame.
- o_rec_len  out  12  forwarded byte count; valid with o_rec_end.
- o_crc_err  out  1  FCS mismatch; valid with o_rec_end.
- o_len_err  out  1  length outside [P_MIN_LEN, P_MAX_LEN]; valid with o_rec_end.
- o_phy_err  out  1  i_gmii_err seen during the frame; valid with o_rec_end.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, CRC register 0xFFFFFFFF, counters 0, delay line empty.
- Valid-history register resets to 1, so a frame already in progress at reset release is ignored.
- FSM states:
  - IDLE: a start requires i_gmii_valid high, the previous cycle's valid low, and data 0x55 → PRE (pre_cnt=1). Valid high with any other byte → DROP.
  - PRE: on each valid byte:
    - 0x55: pre_cnt++; if pre_cnt would exceed P_MAX_PRE → DROP.
    - 0xD5 with pre_cnt ≥ P_MIN_PRE → DATA.
    - anything else → DROP.
    - End of valid → IDLE, with no o_rec_end.
  - DATA: each valid byte updates the CRC, increments frame_cnt (saturates at 4095), and enters the delay line. i_gmii_err ORs into the phy_err flag. End detected → FIN.
  - FIN: one cycle; drives o_rec_end and the status outputs, then → IDLE.
  - DROP: waits for end of valid → IDLE; no outputs.
- End detection:
  - i_speed1000=1: first cycle with valid low.
  - i_speed1000=0: two consecutive valid-low cycles; a single low cycle is a gap.
- Delay line (P_STRIP_FCS=1): 4-byte shift register. A byte is forwarded only when a 5th byte arrives behind it, so the FCS is never output. At end of frame the delay line is discarded.
- Delay line (P_STRIP_FCS=0): every byte is forwarded.
- Latency:
  - o_rec_valid is registered: asserted the cycle after the shifting-in byte's strobe.
  - With T = cycle of the final valid byte, o_rec_end asserts at T+2 (1000 mode) or T+3 (10/100 mode).
  - o_rec_end never coincides with o_rec_valid.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, 8 bits per byte combinationally. Computed over all bytes after the SFD, FCS included. Pass when the register equals 0xDEBB20E3 after the final byte; otherwise o_crc_err=1.
- Length:
  - o_rec_len = forwarded bytes = frame_cnt-4 with strip, floored at 0; frame_cnt without strip.
  - o_len_err uses frame_cnt.
  - Frames under 4 bytes: no data output, o_rec_end still pulses, len_err=1, crc_err=1.
- Oversize frames keep streaming data; the error is reported only at the end.
- CRC register and counters re-initialise on entering DATA, so back-to-back frames with a minimum 1-cycle gap (1000 mode) are handled.
- Reset mid-frame: outputs drop to 0 immediately; no o_rec_end is issued for that frame.

Test Plan:
- 1000 mode: 7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct FCS → 60 o_rec_valid beats carrying 0x00..0x3B, o_rec_end at T+2, o_rec_len=60, all error flags 0.
- Same frame with the last FCS byte XOR 0x01 → identical data, o_crc_err=1, o_len_err=0.
- Runt: 0x55, 0xD5, 20 bytes plus valid FCS → 20 beats, o_rec_len=20, o_len_err=1, o_crc_err=0.
- Preamble 0x55,0x55,0x57,… → no o_rec_valid, no o_rec_end; the next good frame is parsed normally.
- 10/100 mode: good 64-byte frame with a 1-cycle gap after every byte → 60 beats, o_rec_end at T+3, no errors. A 1-cycle gap must not end the frame.
- i_rst pulse at the 30th data byte, valid staying high → outputs cleared, rest of that frame ignored, no o_rec_end. The following good frame passes with no errors.
- i_gmii_err=1 on one payload byte of a good frame → o_phy_err=1 at o_rec_end.
